// File: rtl/axi_info_regs.sv
// axi_info_regs
// AXI4-Lite control/status register slave. It decodes one word-addressed map
// into three regions:
//   - read-only info words that are fixed when the design is built (INFO),
//   - software-writable control registers with byte strobes (ctrl),
//   - live read-only status words that are sampled when a read is accepted (stat).
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   i_s_axi_aw* / o_s_axi_awready   write-address channel
//   i_s_axi_w*  / o_s_axi_wready    write-data channel (data + byte strobes)
//   o_s_axi_b*  / i_s_axi_bready    write-response channel
//   i_s_axi_ar* / o_s_axi_arready   read-address channel
//   o_s_axi_r*  / i_s_axi_rready    read-data channel
//   o_ctrl_q                 current control register values
//   o_ctrl_we                one-cycle pulse per control register written
//   i_stat_d                 live status words
module axi_info_regs #(
    parameter int N_INFO     = 1,
    parameter int N_RW       = 1,
    parameter int N_STAT     = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(N_INFO + N_RW + N_STAT) + $clog2(DATA_WIDTH / 8),
    parameter bit [N_INFO-1:0][DATA_WIDTH-1:0] INFO    = '0,
    parameter bit [N_RW-1:0][DATA_WIDTH-1:0]   RW_INIT = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_s_axi_awvalid,
    output logic                              o_s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]             i_s_axi_awaddr,
    input  logic                              i_s_axi_wvalid,
    output logic                              o_s_axi_wready,
    input  logic [DATA_WIDTH-1:0]             i_s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]           i_s_axi_wstrb,
    output logic                              o_s_axi_bvalid,
    input  logic                              i_s_axi_bready,
    output logic [1:0]                        o_s_axi_bresp,
    input  logic                              i_s_axi_arvalid,
    output logic                              o_s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]             i_s_axi_araddr,
    output logic                              o_s_axi_rvalid,
    input  logic                              i_s_axi_rready,
    output logic [DATA_WIDTH-1:0]             o_s_axi_rdata,
    output logic [1:0]                        o_s_axi_rresp,
    output logic [N_RW-1:0][DATA_WIDTH-1:0]   o_ctrl_q,
    output logic [N_RW-1:0]                   o_ctrl_we,
    input  logic [N_STAT-1:0][DATA_WIDTH-1:0] i_stat_d
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(NBYTES);
    localparam int TOTAL  = N_INFO + N_RW + N_STAT;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        REG_INFO,
        REG_CTRL,
        REG_STAT,
        REG_NONE
    } region_e;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_badWidth
        $error("axi_info_regs: DATA_WIDTH must be 32 or 64");
    end

    // Word indices are widened to 32 bits so that the region limits can be
    // compared directly even when TOTAL is an exact power of two.
    function automatic region_e decodeIdx(input logic [31:0] idx);
        if (idx < 32'(N_INFO)) begin
            return REG_INFO;
        end else if (idx < 32'(N_INFO + N_RW)) begin
            return REG_CTRL;
        end else if (idx < 32'(TOTAL)) begin
            return REG_STAT;
        end
        return REG_NONE;
    endfunction

    // Write-path state
    logic                            r_awHeld;
    logic [ADDR_WIDTH-OFFS-1:0]      r_awIdx;
    logic                            r_wHeld;
    logic [DATA_WIDTH-1:0]           r_wData;
    logic [NBYTES-1:0]               r_wStrb;
    logic                            r_bValid;
    logic [1:0]                      r_bResp;
    logic [N_RW-1:0][DATA_WIDTH-1:0] r_ctrl;
    logic [N_RW-1:0]                 r_ctrlWe;

    // Read-path state
    logic                            r_rValid;
    logic [DATA_WIDTH-1:0]           r_rData;
    logic [1:0]                      r_rResp;

    logic                            w_awHs;
    logic                            w_wHs;
    logic                            w_arHs;
    logic                            w_commit;
    logic [31:0]                     w_awIdx;
    logic [31:0]                     w_arIdx;
    region_e                         w_awRegion;
    region_e                         w_arRegion;
    logic [1:0]                      w_wrResp;
    logic [DATA_WIDTH-1:0]           w_rdData;
    logic [1:0]                      w_rdResp;
    logic                            w_unused;

    // Byte-offset bits inside a word carry no meaning for this map.
    assign w_unused = &{1'b0, i_s_axi_awaddr[OFFS-1:0], i_s_axi_araddr[OFFS-1:0]};

    assign o_s_axi_awready = !r_awHeld;
    assign o_s_axi_wready  = !r_wHeld;
    assign o_s_axi_arready = !r_rValid || i_s_axi_rready;

    assign w_awHs = i_s_axi_awvalid && o_s_axi_awready;
    assign w_wHs  = i_s_axi_wvalid  && o_s_axi_wready;
    assign w_arHs = i_s_axi_arvalid && o_s_axi_arready;

    // A write commits only once both halves are held and the previous
    // response has been taken, so at most one response is ever pending.
    assign w_commit = r_awHeld && r_wHeld && !r_bValid;

    assign w_awIdx    = 32'(r_awIdx);
    assign w_arIdx    = 32'(i_s_axi_araddr[ADDR_WIDTH-1:OFFS]);
    assign w_awRegion = decodeIdx(w_awIdx);
    assign w_arRegion = decodeIdx(w_arIdx);

    always_comb begin
        w_wrResp = RESP_OKAY;
        case (w_awRegion)
            REG_INFO: w_wrResp = RESP_SLVERR;
            REG_STAT: w_wrResp = RESP_SLVERR;
            REG_NONE: w_wrResp = RESP_DECERR;
            default:  w_wrResp = RESP_OKAY;
        endcase
    end

    // Write-address holding register: filled on handshake, emptied on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awHeld <= 1'b0;
            r_awIdx  <= '0;
        end else if (w_awHs) begin
            r_awHeld <= 1'b1;
            r_awIdx  <= i_s_axi_awaddr[ADDR_WIDTH-1:OFFS];
        end else if (w_commit) begin
            r_awHeld <= 1'b0;
        end
    end

    // Write-data holding register, independent of the address side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wHeld <= 1'b0;
            r_wData <= '0;
            r_wStrb <= '0;
        end else if (w_wHs) begin
            r_wHeld <= 1'b1;
            r_wData <= i_s_axi_wdata;
            r_wStrb <= i_s_axi_wstrb;
        end else if (w_commit) begin
            r_wHeld <= 1'b0;
        end
    end

    // Write response: raised by the commit, held until the master takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bValid <= 1'b0;
            r_bResp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bValid <= 1'b1;
            r_bResp  <= w_wrResp;
        end else if (r_bValid && i_s_axi_bready) begin
            r_bValid <= 1'b0;
        end
    end

    // Control registers. The write-enable pulse fires even with an all-zero
    // strobe so software can use a write purely as a trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= RW_INIT;
            r_ctrlWe <= '0;
        end else begin
            r_ctrlWe <= '0;
            if (w_commit && w_awRegion == REG_CTRL) begin
                for (int k = 0; k < N_RW; k++) begin
                    if (w_awIdx == 32'(N_INFO + k)) begin
                        r_ctrlWe[k] <= 1'b1;
                        for (int b = 0; b < NBYTES; b++) begin
                            if (r_wStrb[b]) begin
                                r_ctrl[k][8*b +: 8] <= r_wData[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Read source selection. Loops compare against every legal index so an
    // out-of-range address never indexes past the end of an array.
    always_comb begin
        w_rdData = '0;
        w_rdResp = RESP_OKAY;
        case (w_arRegion)
            REG_INFO: begin
                for (int i = 0; i < N_INFO; i++) begin
                    if (w_arIdx == 32'(i)) begin
                        w_rdData = INFO[i];
                    end
                end
            end
            REG_CTRL: begin
                for (int i = 0; i < N_RW; i++) begin
                    if (w_arIdx == 32'(N_INFO + i)) begin
                        w_rdData = r_ctrl[i];
                    end
                end
            end
            REG_STAT: begin
                for (int i = 0; i < N_STAT; i++) begin
                    if (w_arIdx == 32'(N_INFO + N_RW + i)) begin
                        w_rdData = i_stat_d[i];
                    end
                end
            end
            default: begin
                w_rdResp = RESP_DECERR;
            end
        endcase
    end

    // Read data register: loaded only on an accepted read, so data and
    // response stay frozen while the master stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rValid <= 1'b0;
            r_rData  <= '0;
            r_rResp  <= RESP_OKAY;
        end else if (w_arHs) begin
            r_rValid <= 1'b1;
            r_rData  <= w_rdData;
            r_rResp  <= w_rdResp;
        end else if (i_s_axi_rready) begin
            r_rValid <= 1'b0;
        end
    end

    assign o_s_axi_bvalid = r_bValid;
    assign o_s_axi_bresp  = r_bResp;
    assign o_s_axi_rvalid = r_rValid;
    assign o_s_axi_rdata  = r_rData;
    assign o_s_axi_rresp  = r_rResp;
    assign o_ctrl_q       = r_ctrl;
    assign o_ctrl_we      = r_ctrlWe;

endmodule

// File: tb/tb_axi_info_regs.sv
// tb_axi_info_regs
// Self-checking bench for axi_info_regs with two info words, two control
// registers and two status words on a 32-bit bus. Expected values come from
// a word-level model of the register map kept in this file.
module tb_axi_info_regs;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;

    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic            wvalid;
    logic            wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic [1:0][31:0] ctrlQ;
    logic [1:0]      ctrlWe;
    logic [1:0][31:0] statD;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] infoTbl[2];
    logic [31:0] initCtrl[2];
    logic [31:0] modelCtrl[2];

    always #5 clk = ~clk;

    axi_info_regs #(
        .N_INFO     (2),
        .N_RW       (2),
        .N_STAT     (2),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .INFO       ({32'h00020003, 32'hCAFE0001}),
        .RW_INIT    ({32'h00001111, 32'h00000000})
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_s_axi_awvalid (awvalid),
        .o_s_axi_awready (awready),
        .i_s_axi_awaddr  (awaddr),
        .i_s_axi_wvalid  (wvalid),
        .o_s_axi_wready  (wready),
        .i_s_axi_wdata   (wdata),
        .i_s_axi_wstrb   (wstrb),
        .o_s_axi_bvalid  (bvalid),
        .i_s_axi_bready  (bready),
        .o_s_axi_bresp   (bresp),
        .i_s_axi_arvalid (arvalid),
        .o_s_axi_arready (arready),
        .i_s_axi_araddr  (araddr),
        .o_s_axi_rvalid  (rvalid),
        .i_s_axi_rready  (rready),
        .o_s_axi_rdata   (rdata),
        .o_s_axi_rresp   (rresp),
        .o_ctrl_q        (ctrlQ),
        .o_ctrl_we       (ctrlWe),
        .i_stat_d        (statD)
    );

    // Hard stop in case a handshake never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] mkAddr(input int idx, input logic [1:0] off);
        return {idx[2:0], off};
    endfunction

    // Expected read result from the word index: info, control, status, or a
    // decode error with zero data.
    function automatic void modelRead(input int idx, output logic [31:0] d, output logic [1:0] r);
        d = '0;
        r = 2'b00;
        if (idx < 2)      d = infoTbl[idx];
        else if (idx < 4) d = modelCtrl[idx-2];
        else if (idx < 6) d = statD[idx-4];
        else              r = 2'b11;
    endfunction

    // Applies a write to the model and returns the expected response.
    function automatic logic [1:0] modelWrite(input int idx, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        if (idx >= 6) return 2'b11;
        if (idx < 2 || idx >= 4) return 2'b10;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        modelCtrl[idx-2] = (modelCtrl[idx-2] & ~mask) | (data & mask);
        return 2'b00;
    endfunction

    // Full write transaction with independent AW/W start delays and bready
    // held high; watches response count, latency and write-enable pulses.
    task automatic applyWrite(input int idx, input logic [1:0] off, input logic [31:0] data,
                              input logic [3:0] strb, input int awDelay, input int wDelay,
                              input string tag);
        int c, tail, bCount, weCycles, lastHs, bFirst;
        bit awDone, wDone, weAligned;
        logic [1:0] respSeen, weMask, expResp, expWe;
        c = 0; tail = 0; bCount = 0; weCycles = 0; lastHs = -1; bFirst = -1;
        awDone = 0; wDone = 0; weAligned = 1;
        respSeen = 2'bxx; weMask = 2'b00;
        awaddr = mkAddr(idx, off);
        wdata  = data;
        wstrb  = strb;
        bready = 1'b1;
        while (tail < 3 && c < 40) begin
            awvalid = !awDone && (c >= awDelay);
            wvalid  = !wDone && (c >= wDelay);
            if (bvalid) begin
                bCount++;
                if (bFirst < 0) bFirst = c;
                respSeen = bresp;
            end
            if (ctrlWe != 2'b00) begin
                weCycles++;
                weMask |= ctrlWe;
                if (!bvalid) weAligned = 0;
            end
            if (awvalid && awready) begin
                awDone = 1;
                if (c + 1 > lastHs) lastHs = c + 1;
            end
            if (wvalid && wready) begin
                wDone = 1;
                if (c + 1 > lastHs) lastHs = c + 1;
            end
            tick();
            c++;
            if (bCount > 0) tail++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        expResp = modelWrite(idx, data, strb);
        expWe   = (idx == 2) ? 2'b01 : (idx == 3) ? 2'b10 : 2'b00;
        checkOutput({tag, ".bresp"}, 64'(respSeen), 64'(expResp));
        checkOutput({tag, ".bcount"}, 64'(bCount), 64'(1));
        checkOutput({tag, ".latency"}, 64'(bFirst), 64'(lastHs + 1));
        checkOutput({tag, ".weMask"}, 64'(weMask), 64'(expWe));
        checkOutput({tag, ".weCycles"}, 64'(weCycles), 64'((expWe != 2'b00) ? 1 : 0));
        checkOutput({tag, ".weAligned"}, 64'(weAligned), 64'(1));
        checkOutput({tag, ".ctrl0"}, 64'(ctrlQ[0]), 64'(modelCtrl[0]));
        checkOutput({tag, ".ctrl1"}, 64'(ctrlQ[1]), 64'(modelCtrl[1]));
    endtask

    // Single read with rready high: rvalid must follow the AR handshake by
    // one edge and drop on the next.
    task automatic applyRead(input int idx, input logic [1:0] off, input string tag);
        logic [31:0] expD;
        logic [1:0]  expR;
        int c;
        araddr  = mkAddr(idx, off);
        arvalid = 1'b1;
        rready  = 1'b1;
        c = 0;
        while (!arready && c < 20) begin
            tick();
            c++;
        end
        checkOutput({tag, ".arready"}, 64'(arready), 64'(1));
        modelRead(idx, expD, expR);
        tick();
        arvalid = 1'b0;
        checkOutput({tag, ".rvalid"}, 64'(rvalid), 64'(1));
        checkOutput({tag, ".rdata"}, 64'(rdata), 64'(expD));
        checkOutput({tag, ".rresp"}, 64'(rresp), 64'(expR));
        tick();
        checkOutput({tag, ".rdone"}, 64'(rvalid), 64'(0));
    endtask

    // Randomised mix of reads and writes across the whole map, including
    // unmapped indices and random byte offsets.
    task automatic applyStimulus(input int iterations);
        int idx;
        for (int n = 0; n < iterations; n++) begin
            idx = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 0) begin
                applyWrite(idx, 2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
                           $urandom_range(0, 3), $urandom_range(0, 3), "rndWrite");
            end else begin
                statD[0] = $urandom;
                statD[1] = $urandom;
                applyRead(idx, 2'($urandom_range(0, 3)), "rndRead");
            end
        end
    endtask

    initial begin
        int idx;
        bit sawB;
        logic [31:0] expD;
        logic [1:0]  expR;
        logic [1:0]  dummyResp;

        infoTbl[0]  = 32'hCAFE0001;
        infoTbl[1]  = 32'h00020003;
        initCtrl[0] = 32'h00000000;
        initCtrl[1] = 32'h00001111;
        modelCtrl   = initCtrl;

        rst = 1'b1;
        awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 1;
        arvalid = 0; araddr = '0; rready = 1;
        statD = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst.awready", 64'(awready), 64'(1));
        checkOutput("rst.wready", 64'(wready), 64'(1));
        checkOutput("rst.arready", 64'(arready), 64'(1));
        checkOutput("rst.bvalid", 64'(bvalid), 64'(0));
        checkOutput("rst.rvalid", 64'(rvalid), 64'(0));
        checkOutput("rst.bresp", 64'(bresp), 64'(0));
        checkOutput("rst.rresp", 64'(rresp), 64'(0));
        checkOutput("rst.rdata", 64'(rdata), 64'(0));
        checkOutput("rst.ctrl0", 64'(ctrlQ[0]), 64'(initCtrl[0]));
        checkOutput("rst.ctrl1", 64'(ctrlQ[1]), 64'(initCtrl[1]));
        checkOutput("rst.ctrlWe", 64'(ctrlWe), 64'(0));

        $display("[TB] info reads");
        applyRead(0, 2'd0, "info0");
        applyRead(1, 2'd2, "info1");

        $display("[TB] strobed control write");
        applyWrite(2, 2'd0, 32'hDEADBEEF, 4'b0101, 0, 0, "ctrlStrb");
        checkOutput("ctrlStrb.value", 64'(ctrlQ[0]), 64'(32'h00AD00EF));
        applyRead(2, 2'd0, "ctrlStrbRd");

        $display("[TB] AW/W ordering");
        applyWrite(3, 2'd0, 32'h01234567, 4'b1111, 3, 0, "wFirst");
        applyWrite(2, 2'd1, 32'h89ABCDEF, 4'b1010, 0, 3, "awFirst");
        applyWrite(3, 2'd0, 32'hFFFFFFFF, 4'b0000, 0, 0, "zeroStrb");

        $display("[TB] error responses");
        applyWrite(0, 2'd0, 32'h55555555, 4'b1111, 0, 0, "infoWr");
        applyRead(0, 2'd0, "infoAfterWr");
        applyWrite(5, 2'd0, 32'h66666666, 4'b1111, 1, 0, "statWr");
        applyWrite(7, 2'd3, 32'h77777777, 4'b1111, 0, 1, "unmapWr");
        applyRead(6, 2'd1, "unmapRd");
        applyRead(7, 2'd0, "unmapRd7");

        $display("[TB] status sampling and read stall");
        statD[0] = 32'h12345678;
        araddr   = mkAddr(4, 2'd0);
        arvalid  = 1'b1;
        rready   = 1'b0;
        checkOutput("stall.arready0", 64'(arready), 64'(1));
        tick();
        arvalid = 1'b0;
        checkOutput("stall.rvalid", 64'(rvalid), 64'(1));
        checkOutput("stall.rdata", 64'(rdata), 64'(32'h12345678));
        for (int i = 0; i < 4; i++) begin
            statD[0] = $urandom;
            statD[1] = $urandom;
            tick();
            checkOutput("stall.hold.rdata", 64'(rdata), 64'(32'h12345678));
            checkOutput("stall.hold.rvalid", 64'(rvalid), 64'(1));
            checkOutput("stall.hold.arready", 64'(arready), 64'(0));
        end
        rready = 1'b1;
        tick();
        checkOutput("stall.release", 64'(rvalid), 64'(0));

        $display("[TB] back-to-back reads");
        for (int i = 0; i < 6; i++) begin
            idx      = $urandom_range(0, 7);
            statD[0] = $urandom;
            statD[1] = $urandom;
            araddr   = mkAddr(idx, 2'($urandom_range(0, 3)));
            arvalid  = 1'b1;
            checkOutput("b2b.arready", 64'(arready), 64'(1));
            modelRead(idx, expD, expR);
            tick();
            checkOutput("b2b.rvalid", 64'(rvalid), 64'(1));
            checkOutput("b2b.rdata", 64'(rdata), 64'(expD));
            checkOutput("b2b.rresp", 64'(rresp), 64'(expR));
        end
        arvalid = 1'b0;
        tick();
        checkOutput("b2b.done", 64'(rvalid), 64'(0));

        $display("[TB] reset with pending response and read");
        awaddr  = mkAddr(3, 2'd0);
        wdata   = 32'hAABBCCDD;
        wstrb   = 4'b1111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b0;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        tick();
        checkOutput("midRst.bvalid", 64'(bvalid), 64'(1));
        checkOutput("midRst.we", 64'(ctrlWe), 64'(2'b10));
        checkOutput("midRst.ctrl1", 64'(ctrlQ[1]), 64'(32'hAABBCCDD));
        tick();
        checkOutput("midRst.wePulse", 64'(ctrlWe), 64'(0));
        araddr  = mkAddr(0, 2'd0);
        arvalid = 1'b1;
        rready  = 1'b0;
        awaddr  = mkAddr(2, 2'd0);
        awvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        awvalid = 1'b0;
        checkOutput("midRst.rvalid", 64'(rvalid), 64'(1));
        checkOutput("midRst.awHeld", 64'(awready), 64'(0));
        checkOutput("midRst.bStill", 64'(bvalid), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelCtrl = initCtrl;
        checkOutput("postRst.bvalid", 64'(bvalid), 64'(0));
        checkOutput("postRst.rvalid", 64'(rvalid), 64'(0));
        checkOutput("postRst.awready", 64'(awready), 64'(1));
        checkOutput("postRst.wready", 64'(wready), 64'(1));
        checkOutput("postRst.arready", 64'(arready), 64'(1));
        checkOutput("postRst.ctrlWe", 64'(ctrlWe), 64'(0));
        checkOutput("postRst.ctrl0", 64'(ctrlQ[0]), 64'(initCtrl[0]));
        checkOutput("postRst.ctrl1", 64'(ctrlQ[1]), 64'(initCtrl[1]));

        // Only W after reset: the address captured before reset must be gone.
        bready = 1'b1;
        rready = 1'b1;
        wdata  = 32'h11223344;
        wstrb  = 4'b0011;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        sawB = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid || ctrlWe != 2'b00) sawB = 1;
            tick();
        end
        checkOutput("postRst.noCommit", 64'(sawB), 64'(0));
        checkOutput("postRst.wHeld", 64'(wready), 64'(0));
        awaddr  = mkAddr(2, 2'd1);
        awvalid = 1'b1;
        checkOutput("postRst.awready2", 64'(awready), 64'(1));
        tick();
        awvalid = 1'b0;
        checkOutput("postRst.notYet", 64'(bvalid), 64'(0));
        tick();
        dummyResp = modelWrite(2, 32'h11223344, 4'b0011);
        checkOutput("postRst.bvalid2", 64'(bvalid), 64'(1));
        checkOutput("postRst.bresp2", 64'(bresp), 64'(dummyResp));
        checkOutput("postRst.we2", 64'(ctrlWe), 64'(2'b01));
        checkOutput("postRst.ctrl0b", 64'(ctrlQ[0]), 64'(modelCtrl[0]));
        tick();
        checkOutput("postRst.bdone", 64'(bvalid), 64'(0));
        applyRead(2, 2'd0, "postRst.rd");

        $display("[TB] random traffic");
        applyStimulus(40);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
